// File: rtl/vram_loader.sv
// rtl/vram_loader.sv - paced image ROM to video RAM copy engine
// One word per slot: read, wait out ROM latency, capture, write, then idle until slot end.
module vram_loader #(
  parameter int DATA_W    = 16,
  parameter int VRAM_AW   = 10,
  parameter int ROM_AW    = 11,
  parameter int WORDS     = 1024,
  parameter int IMG_W     = 1,
  parameter int ROM_LAT   = 1,
  parameter int HOLD_LOG2 = 6
) (
  input  logic               write_clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic [IMG_W-1:0]   img_sel,
  output logic               rom_ce,
  output logic [ROM_AW-1:0]  rom_ad,
  input  logic [DATA_W-1:0]  rom_data,
  output logic               vram_ce,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_ad,
  output logic [DATA_W-1:0]  vram_data,
  output logic               busy,
  output logic               frame_done,
  output logic [7:0]         frame_count
);

  localparam int SLOT = ((1 << HOLD_LOG2) > ROM_LAT + 2) ? (1 << HOLD_LOG2) : ROM_LAT + 2;
  localparam int SW   = $clog2(SLOT);
  localparam logic [SW-1:0]      S_LAST = SW'(SLOT - 1);
  localparam logic [SW-1:0]      S_LAT  = SW'(ROM_LAT);
  localparam logic [SW-1:0]      S_WR   = SW'(ROM_LAT + 1);
  localparam logic [VRAM_AW-1:0] I_LAST = VRAM_AW'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, GAP} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      s_q, s_d;
  logic [VRAM_AW-1:0] idx_q, idx_d;
  logic [IMG_W-1:0]   img_q, img_d;
  logic               mode_q, mode_d;

  logic               rom_ce_q, rom_ce_d;
  logic [ROM_AW-1:0]  rom_ad_q, rom_ad_d;
  logic               vram_we_q, vram_we_d;
  logic [VRAM_AW-1:0] vram_ad_q, vram_ad_d;
  logic [DATA_W-1:0]  vram_data_q, vram_data_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic [7:0]         frame_count_q, frame_count_d;

  always_ff @(posedge write_clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      s_q           <= '0;
      idx_q         <= '0;
      img_q         <= '0;
      mode_q        <= 1'b0;
      rom_ce_q      <= 1'b0;
      rom_ad_q      <= '0;
      vram_we_q     <= 1'b0;
      vram_ad_q     <= '0;
      vram_data_q   <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      s_q           <= s_d;
      idx_q         <= idx_d;
      img_q         <= img_d;
      mode_q        <= mode_d;
      rom_ce_q      <= rom_ce_d;
      rom_ad_q      <= rom_ad_d;
      vram_we_q     <= vram_we_d;
      vram_ad_q     <= vram_ad_d;
      vram_data_q   <= vram_data_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    idx_d   = idx_q;
    img_d   = img_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = READ;
          s_d     = '0;
          idx_d   = '0;
          img_d   = img_sel;
          mode_d  = continuous;
        end
      end
      default: begin
        // Refresh mode is re-sampled as the last write of each frame retires.
        if (state_q == WRITE && idx_q == I_LAST)
          mode_d = continuous;
        if (abort) begin
          state_d = IDLE;
        end else if (s_q == S_LAST) begin
          s_d = '0;
          if (idx_q != I_LAST) begin
            idx_d   = idx_q + 1'b1;
            state_d = READ;
          end else if (mode_q) begin
            idx_d   = '0;
            state_d = READ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          s_d = s_q + 1'b1;
          if (s_d <= S_LAT)
            state_d = WAIT;
          else if (s_d == S_WR)
            state_d = WRITE;
          else
            state_d = GAP;
        end
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the upcoming state.
  always_comb begin
    rom_ce_d      = (state_d == READ);
    rom_ad_d      = rom_ce_d ? ROM_AW'(img_d) * ROM_AW'(WORDS) + ROM_AW'(idx_d) : rom_ad_q;
    vram_we_d     = (state_d == WRITE);
    vram_ad_d     = vram_we_d ? idx_d : vram_ad_q;
    frame_done_d  = vram_we_d && (idx_d == I_LAST);
    busy_d        = (state_d != IDLE);
    vram_data_d   = (state_q == WAIT && s_q == S_LAT) ? rom_data : vram_data_q;
    frame_count_d = frame_count_q + {7'd0, frame_done_q};
  end

  assign rom_ce      = rom_ce_q;
  assign rom_ad      = rom_ad_q;
  assign vram_ce     = vram_we_q;
  assign vram_we     = vram_we_q;
  assign vram_ad     = vram_ad_q;
  assign vram_data   = vram_data_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vram_loader.sv
// tb/tb_vram_loader.sv - directed bench for vram_loader (ROM_LAT=1 and ROM_LAT=3 instances)
module tb_vram_loader;

  logic write_clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, abort = 1'b0, continuous = 1'b0;
  logic [0:0] img_sel = 1'b1;
  always #5 write_clk = ~write_clk;

  logic        rom_ce_a, vram_ce_a, vram_we_a, busy_a, frame_done_a;
  logic [10:0] rom_ad_a;
  logic [15:0] rom_data_a = '0, vram_data_a;
  logic [9:0]  vram_ad_a;
  logic [7:0]  frame_count_a;
  logic        rom_ce_b, vram_ce_b, vram_we_b, busy_b, frame_done_b;
  logic [10:0] rom_ad_b;
  logic [15:0] rom_data_b = '0, vram_data_b, pb1 = '0, pb2 = '0;
  logic [9:0]  vram_ad_b;
  logic [7:0]  frame_count_b;

  vram_loader #(.WORDS(4), .ROM_LAT(1), .HOLD_LOG2(2)) dut_a (
    .write_clk(write_clk), .rst(rst), .start(start_a), .abort(abort),
    .continuous(continuous), .img_sel(img_sel), .rom_ce(rom_ce_a), .rom_ad(rom_ad_a),
    .rom_data(rom_data_a), .vram_ce(vram_ce_a), .vram_we(vram_we_a), .vram_ad(vram_ad_a),
    .vram_data(vram_data_a), .busy(busy_a), .frame_done(frame_done_a),
    .frame_count(frame_count_a));

  vram_loader #(.WORDS(4), .ROM_LAT(3), .HOLD_LOG2(1)) dut_b (
    .write_clk(write_clk), .rst(rst), .start(start_b), .abort(abort),
    .continuous(continuous), .img_sel(img_sel), .rom_ce(rom_ce_b), .rom_ad(rom_ad_b),
    .rom_data(rom_data_b), .vram_ce(vram_ce_b), .vram_we(vram_we_b), .vram_ad(vram_ad_b),
    .vram_data(vram_data_b), .busy(busy_b), .frame_done(frame_done_b),
    .frame_count(frame_count_b));

  // ROM models: word at address a holds 0x100 + a
  always @(posedge write_clk) begin
    if (rom_ce_a) rom_data_a <= 16'h100 + {5'd0, rom_ad_a};
    if (rom_ce_b) pb1 <= 16'h100 + {5'd0, rom_ad_b};
    pb2        <= pb1;
    rom_data_b <= pb2;
  end

  int cyc = 0, base = 0, n_chk = 0, n_pass = 0;
  bit sel = 1'b0;
  always @(posedge write_clk) cyc <= cyc + 1;

  int rc_t[$], rc_a[$], wt[$], wa[$], wd[$], fd[$];
  bit busy_log[64];

  always @(negedge write_clk) begin
    int rel;
    #1;
    rel = cyc - base;
    if (rel >= 0 && rel < 64) busy_log[rel] = sel ? busy_b : busy_a;
    if (sel ? rom_ce_b : rom_ce_a) begin
      rc_t.push_back(rel);
      rc_a.push_back(sel ? int'(rom_ad_b) : int'(rom_ad_a));
    end
    if (sel ? (vram_we_b && vram_ce_b) : (vram_we_a && vram_ce_a)) begin
      wt.push_back(rel);
      wa.push_back(sel ? int'(vram_ad_b) : int'(vram_ad_a));
      wd.push_back(sel ? int'(vram_data_b) : int'(vram_data_a));
    end
    if (sel ? frame_done_b : frame_done_a) fd.push_back(rel);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_logs();
    rc_t.delete(); rc_a.delete(); wt.delete(); wa.delete(); wd.delete(); fd.delete();
    for (int i = 0; i < 64; i++) busy_log[i] = 1'b0;
  endtask

  // Start pulse; cycle 0 is the cycle right after the accepting edge.
  task automatic kick(input bit b);
    clear_logs();
    @(negedge write_clk);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge write_clk);
    start_a = 1'b0;
    start_b = 1'b0;
    base = cyc;
  endtask

  task automatic wait_rel(input int n);
    repeat (n) @(negedge write_clk);
    #2;
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    check("rst rom_ce", rom_ce_a, 0);
    check("rst busy", busy_a, 0);
    check("rst vram_we", vram_we_a, 0);
    check("rst frame_count", frame_count_a, 0);
    @(negedge write_clk) rst = 1'b1;

    // one-shot frame, image 1
    kick(0);
    wait_rel(20);
    check("t1 rom_ce count", rc_t.size(), 4);
    check("t1 write count", wt.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1 rom_ce cyc %0d", i), rc_t[i], 4 * i);
      check($sformatf("t1 rom_ad %0d", i), rc_a[i], 4 + i);
      check($sformatf("t1 we cyc %0d", i), wt[i], 2 + 4 * i);
      check($sformatf("t1 vram_ad %0d", i), wa[i], i);
      check($sformatf("t1 data %0d", i), wd[i], 'h104 + i);
    end
    check("t1 frame_done count", fd.size(), 1);
    check("t1 frame_done cyc", fd[0], 14);
    check("t1 busy c0", busy_log[0], 1);
    check("t1 busy c15", busy_log[15], 1);
    check("t1 busy c16", busy_log[16], 0);
    check("t1 frame_count", frame_count_a, 1);

    // continuous, cleared during frame 2
    continuous = 1'b1;
    kick(0);
    repeat (20) @(negedge write_clk);
    continuous = 1'b0;
    wait_rel(16);
    check("t2 rom_ce cyc f2", rc_t[4], 16);
    check("t2 rom_ad f2", rc_a[4], 4);
    check("t2 rom_ce count", rc_t.size(), 8);
    check("t2 frame_done count", fd.size(), 2);
    check("t2 frame_done 0", fd[0], 14);
    check("t2 frame_done 1", fd[1], 30);
    check("t2 busy c31", busy_log[31], 1);
    check("t2 busy c32", busy_log[32], 0);
    check("t2 frame_count", frame_count_a, 3);

    // ROM_LAT=3, SLOT=5
    sel = 1'b1;
    kick(1);
    wait_rel(24);
    check("t3 write count", wt.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3 rom_ce cyc %0d", i), rc_t[i], 5 * i);
      check($sformatf("t3 we cyc %0d", i), wt[i], 4 + 5 * i);
      check($sformatf("t3 data %0d", i), wd[i], 'h104 + i);
    end
    check("t3 busy c19", busy_log[19], 1);
    check("t3 busy c20", busy_log[20], 0);
    check("t3 frame_count", frame_count_b, 1);
    sel = 1'b0;

    // abort at cycle 5
    kick(0);
    repeat (5) @(negedge write_clk);
    abort = 1'b1;
    @(negedge write_clk);
    abort = 1'b0;
    wait_rel(10);
    check("t4 write count", wt.size(), 1);
    check("t4 write cyc", wt[0], 2);
    check("t4 rom_ce count", rc_t.size(), 2);
    check("t4 busy c5", busy_log[5], 1);
    check("t4 busy c6", busy_log[6], 0);
    check("t4 frame_done count", fd.size(), 0);
    check("t4 frame_count", frame_count_a, 3);
    kick(0);
    wait_rel(18);
    check("t4 restart rom_ce cyc", rc_t[0], 0);
    check("t4 restart rom_ad", rc_a[0], 4);
    check("t4 restart frame_count", frame_count_a, 4);

    // start while busy is ignored
    kick(0);
    repeat (3) @(negedge write_clk);
    start_a = 1'b1;
    @(negedge write_clk);
    start_a = 1'b0;
    wait_rel(16);
    check("t5 rom_ce count", rc_t.size(), 4);
    check("t5 busy c16", busy_log[16], 0);
    check("t5 frame_count", frame_count_a, 5);

    // start with abort in IDLE is ignored
    clear_logs();
    @(negedge write_clk);
    start_a = 1'b1;
    abort = 1'b1;
    @(negedge write_clk);
    start_a = 1'b0;
    abort = 1'b0;
    wait_rel(10);
    check("t5 start+abort rom_ce", rc_t.size(), 0);
    check("t5 start+abort busy", busy_a, 0);

    // asynchronous reset mid-copy
    kick(0);
    repeat (7) @(negedge write_clk);
    #2;
    check("t6 pre data", vram_data_a, 'h105);
    check("t6 pre busy", busy_a, 1);
    #1 rst = 1'b0;
    #1;
    check("t6 busy", busy_a, 0);
    check("t6 frame_count", frame_count_a, 0);
    check("t6 vram_data", vram_data_a, 0);
    check("t6 vram_ad", vram_ad_a, 0);
    check("t6 rom_ad", rom_ad_a, 0);
    check("t6 frame_count b", frame_count_b, 0);
    @(negedge write_clk) rst = 1'b1;
    clear_logs();
    wait_rel(10);
    check("t6 idle rom_ce", rc_t.size(), 0);
    check("t6 idle busy", busy_a, 0);
    kick(0);
    wait_rel(3);
    check("t6 restart rom_ad", rc_a[0], 4);
    check("t6 restart rom_ce cyc", rc_t[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vram_loader.md
Name: vram_loader

Overview:
Parametrised engine in the write_clk domain that copies an image from a synchronous image ROM into video RAM. It supports selectable images, a configurable ROM read latency, configurable per-word pacing, one-shot or continuous refresh, and abort. It replaces the free-running write-address counter that fed the video RAM write port. It also reports busy, frame-complete and frame-count status to the pixel-side logic.

Parameters:
DATA_W, 16, pixel word width (RGB565 default)
VRAM_AW, 10, video RAM address width
ROM_AW, 11, image ROM address width
WORDS, 1024, words per image (1..2^VRAM_AW)
IMG_W, 1, width of image select
ROM_LAT, 1, ROM read latency in cycles (>=1)
HOLD_LOG2, 6, nominal slot length per word = 2^HOLD_LOG2 cycles

Ports:
write_clk  in  1  write-domain clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin a copy; ignored while busy=1
abort  in  1  stop the current copy; takes priority over start
continuous  in  1  1=restart at word 0 after last word; 0=one-shot; sampled at start and at each frame end
img_sel  in  IMG_W  image index; latched on accepted start
rom_ce  out  1  ROM read enable
rom_ad  out  ROM_AW  ROM address
rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_ce
vram_ce  out  1  video RAM write-port clock enable
vram_we  out  1  video RAM write strobe
vram_ad  out  VRAM_AW  video RAM write address
vram_data  out  DATA_W  video RAM write data
busy  out  1  copy in progress
frame_done  out  1  one-cycle pulse coincident with the last write of a frame
frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (rst=0, asynchronous): every output is 0; state IDLE; latched img_sel, mode and word index are 0. Takes effect immediately, including mid-copy.
- All outputs are registered.
- Slot length SLOT = max(2^HOLD_LOG2, ROM_LAT+2). Slot cycles are numbered s = 0..SLOT-1.
- States: IDLE, READ (s=0), WAIT (s=1..ROM_LAT), WRITE (s=ROM_LAT+1), GAP (remaining cycles of the slot).
- IDLE: on the edge where start=1 and abort=0, latch img_sel and continuous, set idx=0, enter READ. busy goes to 1 in that same registered cycle.
- READ: rom_ce=1; rom_ad = (img_sel*WORDS + idx) truncated to ROM_AW.
- WAIT: rom_ce=0. At the end of cycle s=ROM_LAT, rom_data is captured into vram_data.
- WRITE: vram_ce=1, vram_we=1, vram_ad=idx, for exactly one cycle. vram_data holds the captured value until the next capture.
- GAP: all strobes 0 until the slot ends. Then idx+1, READ.
- The last word is idx=WORDS-1. frame_done=1 during its WRITE cycle, and frame_count increments at the end of that cycle.
- After the last slot:
  - continuous=1: re-sample continuous, idx=0, READ with no idle cycle; busy stays 1; img_sel is not re-latched.
  - continuous=0: IDLE; busy=0 in the cycle after the final GAP cycle.
- abort=1 in any non-IDLE state: IDLE at the next edge, busy=0, no further rom_ce or vram_we. A WRITE already being driven in the abort cycle completes. frame_done is not generated for an aborted frame.
- start while busy=1 is ignored. start and abort in the same cycle: abort wins, remain or return IDLE.
- vram_ad wraps naturally only if WORDS=2^VRAM_AW. Otherwise the sequence ends at WORDS-1.
- ROM address arithmetic overflow truncates silently to ROM_AW bits.

Test Plan:
- WORDS=4, HOLD_LOG2=2, ROM_LAT=1, ROM returns 0x100+addr, img_sel=1, one-shot, start at cycle 0 -> rom_ce at cycles 0,4,8,12 with rom_ad 4..7; vram_we at cycles 2,6,10,14 with vram_ad 0..3 and data 0x104..0x107; frame_done only at cycle 14; frame_count=1; busy high cycles 0..15, low at 16.
- Same config, continuous=1 -> second frame's rom_ce at cycle 16 with rom_ad 4; frame_done at cycles 14 and 30; clear continuous during frame 2 -> busy low at cycle 32.
- ROM_LAT=3, HOLD_LOG2=1 -> SLOT=5; vram_we 4 cycles after each rom_ce; writes spaced 5 cycles; data matches the ROM model.
- abort asserted at cycle 5 of the first config -> write at cycle 6 does not occur; busy=0 from cycle 6; frame_count unchanged; a new start then restarts at rom_ad 4.
- start during busy, and start+abort together in IDLE -> both ignored; no rom_ce.
- rst pulsed low at cycle 7 -> all outputs 0 asynchronously; frame_count=0; engine idle after release until the next start.
